// File: rtl/sketch_pkg.sv
// Shared types and helpers for the bytebeat sketch sequencer: FSM states, program
// entry layout and fade arithmetic.
package sketch_pkg;

    // The voice count lives here because the entry struct width depends on it.
    localparam int NV = 4;
    localparam int VW = (NV > 1) ? $clog2(NV) : 1;

    localparam logic [7:0] FADE_MAX = 8'd255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        FADE = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [VW-1:0] voice;
        logic [7:0]    bars;
    } seq_entry_t;

    // A zero-length section still plays one bar.
    function automatic logic [7:0] bars_floor(input logic [7:0] b);
        return (b == 8'd0) ? 8'd1 : b;
    endfunction

    function automatic logic [7:0] fade_add(input logic [7:0] f, input logic [7:0] step);
        logic [8:0] s;
        s = {1'b0, f} + {1'b0, step};
        return (s > 9'd255) ? FADE_MAX : s[7:0];
    endfunction

endpackage

// File: rtl/sketch_sequencer_if.sv
// Program-write channel into the sequencer. A write is accepted on any dspclk edge
// where prog_valid and prog_ready are both high; the writer holds its fields while valid.
interface sketch_sequencer_if;
    import sketch_pkg::*;

    logic          prog_valid;
    logic          prog_ready;
    logic [VW-1:0] prog_voice;
    logic [7:0]    prog_bars;
    logic          prog_last;

    modport master (
        output prog_valid,
        output prog_voice,
        output prog_bars,
        output prog_last,
        input  prog_ready
    );

    modport slave (
        input  prog_valid,
        input  prog_voice,
        input  prog_bars,
        input  prog_last,
        output prog_ready
    );

endinterface

// File: rtl/sketch_sequencer_prog_mem.sv
// Program entry register file: one write port, two asynchronous read ports
// (current entry and next-entry lookahead). Contents are deliberately not reset.
module seq_prog_mem
    import sketch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic            dspclk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  seq_entry_t      wdata,
    input  logic [AW-1:0]   raddr_a,
    input  logic [AW-1:0]   raddr_b,
    output seq_entry_t      rdata_a,
    output seq_entry_t      rdata_b
);

    seq_entry_t mem [DEPTH];

    always_ff @(posedge dspclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/sketch_sequencer.sv
// Time base and arrangement controller: advances t at a programmable rate, walks the
// (voice, bars) program and crossfades between outgoing and incoming voices.
module sketch_sequencer
    import sketch_pkg::*;
#(
    parameter int TW        = 32,
    parameter int DEPTH     = 8,
    parameter int BAR_LOG2  = 15,
    parameter int FADE_STEP = 1
) (
    input  logic              dspclk,
    input  logic              n_reset,
    input  logic              run,
    input  logic [7:0]        rate,
    sketch_sequencer_if.slave prog,
    output logic [TW-1:0]     t,
    output logic [VW-1:0]     voice_cur,
    output logic [VW-1:0]     voice_prev,
    output logic [7:0]        fade,
    output logic              bar_tick,
    output logic              playing,
    output seq_state_e        state_dbg
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = AW + 1;
    localparam logic [7:0] STEP = 8'(FADE_STEP);

    seq_state_e    state, state_nxt;
    logic [7:0]    presc;
    logic [AW-1:0] wptr;
    logic [LW-1:0] len;
    logic [AW-1:0] ptr;
    logic [AW-1:0] nxt_ptr;
    logic [7:0]    bars_left;
    logic [7:0]    fade_sum;
    seq_entry_t    wr_entry, ent_cur, ent_nxt;

    logic wr_fire, wr_wrap, active, do_start, do_stop;
    logic tick, bar_end, sec_end, voice_change, fade_done;

    assign wr_entry = '{voice: prog.prog_voice, bars: prog.prog_bars};

    // ptr is held at 0 while idle, so port A doubles as the entry-0 lookup at start.
    seq_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .dspclk  (dspclk),
        .we      (wr_fire),
        .waddr   (wptr),
        .wdata   (wr_entry),
        .raddr_a (ptr),
        .raddr_b (nxt_ptr),
        .rdata_a (ent_cur),
        .rdata_b (ent_nxt)
    );

    always_comb begin
        wr_fire      = prog.prog_valid && prog.prog_ready;
        wr_wrap      = prog.prog_last || (wptr == AW'(DEPTH - 1));
        active       = (state != IDLE);
        do_start     = (state == IDLE) && run && !wr_fire && (len != '0);
        do_stop      = active && !run;
        tick         = active && run && (presc == rate);
        bar_end      = tick && (&t[BAR_LOG2-1:0]);
        sec_end      = bar_end && (bars_left <= 8'd1);
        nxt_ptr      = ((LW'(ptr) + LW'(1)) == len) ? '0 : ptr + AW'(1);
        voice_change = sec_end && (ent_nxt.voice != voice_cur);
        fade_sum     = fade_add(fade, STEP);
        fade_done    = (state == FADE) && tick && (fade_sum == FADE_MAX) && !voice_change;
    end

    always_ff @(posedge dspclk) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (do_start) state_nxt = PLAY;
            PLAY: begin
                if (!run) state_nxt = IDLE;
                else if (voice_change) state_nxt = FADE;
            end
            FADE: begin
                if (!run) state_nxt = IDLE;
                else if (voice_change) state_nxt = FADE;
                else if (fade_done) state_nxt = PLAY;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        prog.prog_ready = (state == IDLE);
        playing         = active;
        state_dbg       = state;
    end

    always_ff @(posedge dspclk) begin
        if (!n_reset) begin
            t          <= '0;
            presc      <= 8'd0;
            wptr       <= '0;
            len        <= '0;
            ptr        <= '0;
            voice_cur  <= '0;
            voice_prev <= '0;
            fade       <= FADE_MAX;
            bar_tick   <= 1'b0;
            bars_left  <= 8'd0;
        end else begin
            bar_tick <= bar_end;
            if (wr_fire) begin
                if (wr_wrap) begin
                    len  <= LW'(wptr) + LW'(1);
                    wptr <= '0;
                end else begin
                    wptr <= wptr + AW'(1);
                end
            end
            if (do_start) begin
                t          <= '0;
                presc      <= 8'd0;
                ptr        <= '0;
                voice_cur  <= ent_cur.voice;
                voice_prev <= ent_cur.voice;
                bars_left  <= bars_floor(ent_cur.bars);
                fade       <= FADE_MAX;
            end else if (do_stop) begin
                // t is held so the datapaths freeze on the last sample.
                fade       <= FADE_MAX;
                voice_prev <= voice_cur;
                ptr        <= '0;
                presc      <= 8'd0;
            end else if (tick) begin
                presc <= 8'd0;
                t     <= t + TW'(1);
                if (sec_end) begin
                    ptr       <= nxt_ptr;
                    bars_left <= bars_floor(ent_nxt.bars);
                end else if (bar_end) begin
                    bars_left <= bars_left - 8'd1;
                end
                if (voice_change) begin
                    voice_prev <= voice_cur;
                    voice_cur  <= ent_nxt.voice;
                    fade       <= 8'd0;
                end else if (state == FADE) begin
                    fade <= fade_sum;
                    if (fade_done) voice_prev <= voice_cur;
                end
            end else if (active) begin
                presc <= presc + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sketch_sequencer.sv
// Bench for sketch_sequencer: directed programs, a bar_tick-driven scoreboard and
// point checks of reset, rate, stop/restart and reset-abort behaviour.
module tb_sketch_sequencer;
    import sketch_pkg::*;

    localparam int SW = 32 + 2 * VW + 8;

    logic        dspclk;
    logic        n_reset;
    logic        run;
    logic [7:0]  rate;
    logic [31:0] t;
    logic [VW-1:0] voice_cur, voice_prev;
    logic [7:0]  fade;
    logic        bar_tick, playing;
    seq_state_e  state_dbg;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] mon_exp, mon_act;
    logic [VW-1:0] dvoice [8];

    sketch_sequencer_if pif ();

    sketch_sequencer #(
        .TW        (32),
        .DEPTH     (8),
        .BAR_LOG2  (4),
        .FADE_STEP (16)
    ) dut (
        .dspclk     (dspclk),
        .n_reset    (n_reset),
        .run        (run),
        .rate       (rate),
        .prog       (pif),
        .t          (t),
        .voice_cur  (voice_cur),
        .voice_prev (voice_prev),
        .fade       (fade),
        .bar_tick   (bar_tick),
        .playing    (playing),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial dspclk = 1'b0;
    always #5 dspclk = ~dspclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [SW-1:0] pack(input logic [31:0] tv, input logic [VW-1:0] c,
                                           input logic [VW-1:0] p, input logic [7:0] f);
        return {tv, c, p, f};
    endfunction

    // driver tasks
    task automatic step();
        @(posedge dspclk);
        #1;
        cyc++;
    endtask

    task automatic to_cycle(input int k);
        while (cyc < k) step();
    endtask

    task automatic prog_write(input logic [VW-1:0] v, input logic [7:0] b, input logic last);
        pif.prog_valid = 1'b1;
        pif.prog_voice = v;
        pif.prog_bars  = b;
        pif.prog_last  = last;
        step();
        pif.prog_valid = 1'b0;
        pif.prog_last  = 1'b0;
    endtask

    task automatic start_play();
        run = 1'b1;
        step();
        cyc = 0;
    endtask

    task automatic stop_play();
        run = 1'b0;
        step();
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, expv);
        end
    endtask

    // scoreboard monitor: every bar_tick pulse consumes one expected snapshot
    always @(negedge dspclk) begin
        if (n_reset && bar_tick) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL bar_tick: unexpected pulse at t=%0d, required no pulse", t);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_act = pack(t, voice_cur, voice_prev, fade);
                if (mon_act !== mon_exp) begin
                    n_bad++;
                    $display("FAIL bar_tick: got t=%0d cur=%0d prev=%0d fade=%0d required t=%0d cur=%0d prev=%0d fade=%0d",
                             mon_act[SW-1 -: 32], mon_act[2*VW+7 -: VW], mon_act[VW+7 -: VW], mon_act[7:0],
                             mon_exp[SW-1 -: 32], mon_exp[2*VW+7 -: VW], mon_exp[VW+7 -: VW], mon_exp[7:0]);
                end
            end
        end
    end

    initial begin
        n_reset = 1'b0;
        run = 1'b0;
        rate = 8'd0;
        pif.prog_valid = 1'b0;
        pif.prog_voice = '0;
        pif.prog_bars = 8'd0;
        pif.prog_last = 1'b0;

        // reset
        repeat (3) step();
        check("rst_t", t, 0);
        check("rst_fade", fade, 255);
        check("rst_ready", pif.prog_ready, 1);
        check("rst_playing", playing, 0);
        check("rst_bar_tick", bar_tick, 0);
        n_reset = 1'b1;
        step();
        check("rst_state", state_dbg, IDLE);

        // rate: t every 3 cycles, bar every 48
        prog_write(2'd1, 8'd1, 1'b1);
        rate = 8'd2;
        exp_q.push_back(pack(32'd16, 2'd1, 2'd1, 8'd255));
        exp_q.push_back(pack(32'd32, 2'd1, 2'd1, 8'd255));
        start_play();
        check("a_t0", t, 0);
        check("a_playing", playing, 1);
        check("a_ready_busy", pif.prog_ready, 0);
        to_cycle(2);  check("a_t_c2", t, 0);
        to_cycle(3);  check("a_t_c3", t, 1);
        to_cycle(6);  check("a_t_c6", t, 2);
        to_cycle(100);
        stop_play();
        check("a_stop_playing", playing, 0);
        check("a_stop_t", t, 33);
        check("a_stop_fade", fade, 255);

        // crossfade {1,1},{2,2}
        prog_write(2'd1, 8'd1, 1'b0);
        prog_write(2'd2, 8'd2, 1'b1);
        rate = 8'd0;
        exp_q.push_back(pack(32'd16, 2'd2, 2'd1, 8'd0));
        exp_q.push_back(pack(32'd32, 2'd2, 2'd2, 8'd255));
        exp_q.push_back(pack(32'd48, 2'd1, 2'd2, 8'd0));
        start_play();
        check("b_cur0", voice_cur, 1);
        check("b_prev0", voice_prev, 1);
        check("b_fade0", fade, 255);
        to_cycle(20);
        check("b_fade_c20", fade, 64);
        check("b_state_c20", state_dbg, FADE);
        check("b_prev_c20", voice_prev, 1);
        to_cycle(40);
        check("b_state_c40", state_dbg, PLAY);
        check("b_fade_c40", fade, 255);
        to_cycle(50);
        stop_play();

        // stop mid-fade, then restart
        exp_q.push_back(pack(32'd16, 2'd2, 2'd1, 8'd0));
        start_play();
        to_cycle(20);
        stop_play();
        check("s_state", state_dbg, IDLE);
        check("s_playing", playing, 0);
        check("s_t_held", t, 20);
        check("s_fade", fade, 255);
        check("s_prev", voice_prev, 2);
        step();
        step();
        check("s_t_held2", t, 20);
        start_play();
        check("s_restart_t", t, 0);
        check("s_restart_cur", voice_cur, 1);
        check("s_restart_prev", voice_prev, 1);
        check("s_restart_fade", fade, 255);
        stop_play();

        // same voice {3,2},{3,1}
        prog_write(2'd3, 8'd2, 1'b0);
        prog_write(2'd3, 8'd1, 1'b1);
        exp_q.push_back(pack(32'd16, 2'd3, 2'd3, 8'd255));
        exp_q.push_back(pack(32'd32, 2'd3, 2'd3, 8'd255));
        exp_q.push_back(pack(32'd48, 2'd3, 2'd3, 8'd255));
        start_play();
        to_cycle(33);
        check("c_state_c33", state_dbg, PLAY);
        check("c_fade_c33", fade, 255);
        to_cycle(50);
        stop_play();

        // overflow: 9 writes without last; the 9th lands at entry 0
        for (int i = 0; i < 8; i++) prog_write(VW'(i % 4), 8'd1, 1'b0);
        prog_write(2'd2, 8'd0, 1'b0);
        dvoice = '{2'd2, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        for (int k = 1; k <= 8; k++)
            exp_q.push_back(pack(32'(16 * k), dvoice[k % 8], dvoice[(k - 1) % 8], 8'd0));
        start_play();
        check("d_cur0", voice_cur, 2);
        to_cycle(130);

        // reset mid-operation invalidates the program
        n_reset = 1'b0;
        step();
        step();
        n_reset = 1'b1;
        repeat (3) step();
        check("r_playing", playing, 0);
        check("r_t", t, 0);
        check("r_fade", fade, 255);
        check("r_ready", pif.prog_ready, 1);
        run = 1'b0;
        step();

        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
